cv32e40x_xif_offload_ctrl: RTL and testbench

- Core-side initiator of the eXtension interface: offers instructions to a coprocessor, sends the commit/kill decision, consumes results and writes them to the register file.
- It is the counterpart of the coprocessor-side AES responder.
- Sits between the ID/EX offload decision logic and the XIF issue/commit/result channels.
- Tracks outstanding accepted instructions in a small ID table.

---
 rtl/cv32e40x_xif_offload_ctrl_if.sv | 73 +++++++
 rtl/cv32e40x_xif_offload_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cv32e40x_xif_offload_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40x_xif_offload_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cv32e40x_xif_offload_ctrl_if : offer, XIF issue/commit/result, RF bundle    |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
interface cv32e40x_xif_offload_ctrl_if #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFR_WIDTH = 32,
  parameter int X_RFW_WIDTH = 32
) ();
  logic                   off_valid;
  logic                   off_ready;
  logic [31:0]            off_instr;
  logic [X_ID_WIDTH-1:0]  off_id;
  logic [X_RFR_WIDTH-1:0] off_rs1;
  logic [X_RFR_WIDTH-1:0] off_rs2;
  logic                   off_kill;
  logic                   off_done;
  logic                   off_accept;

  logic                   x_issue_valid;
  logic                   x_issue_ready;
  logic [31:0]            x_issue_instr;
  logic [X_ID_WIDTH-1:0]  x_issue_id;
  logic [X_RFR_WIDTH-1:0] x_issue_rs0;
  logic [X_RFR_WIDTH-1:0] x_issue_rs1;
  logic [1:0]             x_issue_rs_valid;
  logic                   x_issue_accept;
  logic                   x_issue_writeback;

  logic                   x_commit_valid;
  logic [X_ID_WIDTH-1:0]  x_commit_id;
  logic                   x_commit_kill;

  logic                   x_result_valid;
  logic                   x_result_ready;
  logic [X_ID_WIDTH-1:0]  x_result_id;
  logic [X_RFW_WIDTH-1:0] x_result_data;
  logic [4:0]             x_result_rd;
  logic                   x_result_we;

  logic                   rf_stall;
  logic                   rf_we;
  logic [4:0]             rf_waddr;
  logic [X_RFW_WIDTH-1:0] rf_wdata;
  logic [3:0]             outstanding_cnt;
  logic                   err_unexp_result;

  modport master (
    input  off_valid, off_instr, off_id, off_rs1, off_rs2, off_kill,
    output off_ready, off_done, off_accept,
    output x_issue_valid, x_issue_instr, x_issue_id, x_issue_rs0, x_issue_rs1, x_issue_rs_valid,
    input  x_issue_ready, x_issue_accept, x_issue_writeback,
    output x_commit_valid, x_commit_id, x_commit_kill,
    input  x_result_valid, x_result_id, x_result_data, x_result_rd, x_result_we,
    output x_result_ready,
    input  rf_stall,
    output rf_we, rf_waddr, rf_wdata, outstanding_cnt, err_unexp_result
  );

  modport slave (
    output off_valid, off_instr, off_id, off_rs1, off_rs2, off_kill,
    input  off_ready, off_done, off_accept,
    input  x_issue_valid, x_issue_instr, x_issue_id, x_issue_rs0, x_issue_rs1, x_issue_rs_valid,
    output x_issue_ready, x_issue_accept, x_issue_writeback,
    input  x_commit_valid, x_commit_id, x_commit_kill,
    output x_result_valid, x_result_id, x_result_data, x_result_rd, x_result_we,
    input  x_result_ready,
    output rf_stall,
    input  rf_we, rf_waddr, rf_wdata, outstanding_cnt, err_unexp_result
  );
endinterface
`default_nettype wire

// File: rtl/cv32e40x_xif_offload_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cv32e40x_xif_offload_ctrl : XIF initiator - issue, commit, result writeback |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module cv32e40x_xif_offload_ctrl #(
  parameter int X_ID_WIDTH    = 4,
  parameter int X_RFR_WIDTH   = 32,
  parameter int X_RFW_WIDTH   = 32,
  parameter int X_OUTSTANDING = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  cv32e40x_xif_offload_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [X_OUTSTANDING-1:0] c_ONE = X_OUTSTANDING'(1);

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic [31:0]            r_instr;
  logic [X_ID_WIDTH-1:0]  r_id;
  logic [X_RFR_WIDTH-1:0] r_rs0;
  logic [X_RFR_WIDTH-1:0] r_rs1;
  logic                   r_kill_sticky;
  logic                   r_commit_kill;
  logic                   r_err;

  logic [X_OUTSTANDING-1:0] r_valid;
  logic [X_ID_WIDTH-1:0]    r_tab_id [X_OUTSTANDING];

  logic [X_OUTSTANDING-1:0] w_off_match;
  logic [X_OUTSTANDING-1:0] w_res_match;
  logic [X_OUTSTANDING-1:0] w_alloc_vec;
  logic [X_OUTSTANDING-1:0] w_free_vec;
  logic [3:0]               w_cnt;
  logic                     w_off_ready;
  logic                     w_issue_valid;
  logic                     w_commit_valid;
  logic                     w_offer_hs;
  logic                     w_issue_hs;
  logic                     w_result_hs;
  logic                     w_res_hit;
  logic                     w_kill_eff;
  logic                     w_alloc;
  logic                     w_rf_we;

  generate
    for (genvar g = 0; g < X_OUTSTANDING; g++) begin : g_match
      assign w_off_match[g] = r_valid[g] && (r_tab_id[g] == bus.off_id);
      assign w_res_match[g] = r_valid[g] && (r_tab_id[g] == bus.x_result_id);
    end
  endgenerate

  always_comb begin
    w_cnt = 4'd0;
    for (int i = 0; i < X_OUTSTANDING; i++) begin
      w_cnt = w_cnt + {3'b000, r_valid[i]};
    end
  end

  assign w_offer_hs  = bus.off_valid && w_off_ready;
  assign w_issue_hs  = (r_state == S_ISSUE) && bus.x_issue_ready;
  assign w_result_hs = bus.x_result_valid && !bus.rf_stall;
  assign w_res_hit   = |w_res_match;
  assign w_kill_eff  = r_kill_sticky || bus.off_kill;
  assign w_alloc     = w_issue_hs && bus.x_issue_accept && bus.x_issue_writeback && !w_kill_eff;
  // Lowest clear bit of r_valid; the offer gate guarantees one exists when allocating.
  assign w_alloc_vec = w_alloc ? (~r_valid & (r_valid + c_ONE)) : '0;
  assign w_free_vec  = w_result_hs ? w_res_match : '0;
  assign w_rf_we     = w_result_hs && w_res_hit && bus.x_result_we && (bus.x_result_rd != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_offer_hs) w_next_state = S_ISSUE;
      S_ISSUE:  if (bus.x_issue_ready) w_next_state = S_COMMIT;
      S_COMMIT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_off_ready    = 1'b0;
    w_issue_valid  = 1'b0;
    w_commit_valid = 1'b0;
    case (r_state)
      S_IDLE:   w_off_ready    = (w_cnt < 4'(X_OUTSTANDING)) && !(|w_off_match);
      S_ISSUE:  w_issue_valid  = 1'b1;
      S_COMMIT: w_commit_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr       <= '0;
      r_id          <= '0;
      r_rs0         <= '0;
      r_rs1         <= '0;
      r_kill_sticky <= 1'b0;
      r_commit_kill <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_offer_hs) begin
        r_instr       <= bus.off_instr;
        r_id          <= bus.off_id;
        r_rs0         <= bus.off_rs1;
        r_rs1         <= bus.off_rs2;
        r_kill_sticky <= 1'b0;
      end else if ((r_state == S_ISSUE) && bus.off_kill) begin
        r_kill_sticky <= 1'b1;
      end
      // A rejected offload is committed as killed so the coprocessor can retire its ID.
      if (w_issue_hs) begin
        r_commit_kill <= w_kill_eff || !bus.x_issue_accept;
      end
      if (w_result_hs && !w_res_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < X_OUTSTANDING; i++) begin
        r_tab_id[i] <= '0;
      end
    end else begin
      for (int i = 0; i < X_OUTSTANDING; i++) begin
        if (w_alloc_vec[i]) begin
          r_valid[i]  <= 1'b1;
          r_tab_id[i] <= r_id;
        end else if (w_free_vec[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.off_ready        = w_off_ready;
  assign bus.off_done         = w_commit_valid;
  assign bus.off_accept       = w_commit_valid && !r_commit_kill;
  assign bus.x_issue_valid    = w_issue_valid;
  assign bus.x_issue_instr    = r_instr;
  assign bus.x_issue_id       = r_id;
  assign bus.x_issue_rs0      = r_rs0;
  assign bus.x_issue_rs1      = r_rs1;
  assign bus.x_issue_rs_valid = w_issue_valid ? 2'b11 : 2'b00;
  assign bus.x_commit_valid   = w_commit_valid;
  assign bus.x_commit_id      = w_commit_valid ? r_id : '0;
  assign bus.x_commit_kill    = w_commit_valid && r_commit_kill;
  assign bus.x_result_ready   = !bus.rf_stall;
  assign bus.rf_we            = w_rf_we;
  assign bus.rf_waddr         = w_rf_we ? bus.x_result_rd : 5'd0;
  assign bus.rf_wdata         = w_rf_we ? bus.x_result_data : {X_RFW_WIDTH{1'b0}};
  assign bus.outstanding_cnt  = w_cnt;
  assign bus.err_unexp_result = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40x_xif_offload_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cv32e40x_xif_offload_ctrl : scoreboard bench with a set-of-IDs model     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_cv32e40x_xif_offload_ctrl;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40x_xif_offload_ctrl_if #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32), .X_RFW_WIDTH(32)) xif ();

  cv32e40x_xif_offload_ctrl #(
    .X_ID_WIDTH(4), .X_RFR_WIDTH(32), .X_RFW_WIDTH(32), .X_OUTSTANDING(N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (xif.master)
  );

  typedef struct packed { logic [31:0] instr; logic [3:0] id; logic [31:0] rs0; logic [31:0] rs1; } iss_t;
  typedef struct packed { logic [3:0] id; logic kill; } cmt_t;
  typedef struct packed { logic we; logic [4:0] rd; logic [31:0] data; } res_t;

  iss_t       q_iss[$];
  cmt_t       q_cmt[$];
  res_t       q_res[$];
  logic [3:0] ids[$];   // IDs the coprocessor still owes a result for
  bit         model_err;
  int         checks = 0;
  int         errors = 0;
  bit         exp_issue = 1'b0;
  bit         exp_commit = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual event-without-expectation required expectation", name);
  endtask

  function automatic bit in_set(input logic [3:0] id);
    foreach (ids[i]) if (ids[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    xif.off_valid = 0; xif.off_instr = 0; xif.off_id = 0; xif.off_rs1 = 0; xif.off_rs2 = 0;
    xif.off_kill = 0; xif.x_issue_ready = 0; xif.x_issue_accept = 0; xif.x_issue_writeback = 0;
    xif.x_result_valid = 0; xif.x_result_id = 0; xif.x_result_data = 0; xif.x_result_rd = 0;
    xif.x_result_we = 0; xif.rf_stall = 0;
  endtask

  // Register a result handshake with the model: hit frees the ID, miss sets the error.
  task automatic res_expect(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd, input bit we);
    res_t r;
    int   idx;
    idx = -1;
    foreach (ids[i]) if (ids[i] == id) idx = i;
    r.we   = (idx >= 0) && we && (rd != 5'd0);
    r.rd   = rd;
    r.data = data;
    q_res.push_back(r);
    if (idx >= 0) ids.delete(idx);
    else model_err = 1'b1;
  endtask

  task automatic check_ready(input logic [3:0] id);
    xif.off_id = id;
    #1;
    chk("off_ready", 64'(xif.off_ready), 64'((ids.size() < N) && !in_set(id)));
  endtask

  task automatic offload(input logic [3:0] id, input logic [31:0] instr, input logic [31:0] rs1,
                         input logic [31:0] rs2, input bit acc, input bit wb, input int delay,
                         input int kill_at, input bit res_en, input logic [3:0] res_id,
                         input logic [31:0] res_data, input logic [4:0] res_rd);
    int   n;
    bit   kill;
    iss_t ie;
    xif.off_valid = 1; xif.off_id = id; xif.off_instr = instr; xif.off_rs1 = rs1; xif.off_rs2 = rs2;
    #1;
    n = 0;
    while (!xif.off_ready && n < 20) begin tick(); n++; end
    if (n == 20) begin
      chk("offer_timeout", 64'(xif.off_ready), 64'(1));
      xif.off_valid = 0;
      return;
    end
    ie.instr = instr; ie.id = id; ie.rs0 = rs1; ie.rs1 = rs2;
    q_iss.push_back(ie);
    tick();
    xif.off_valid = 0; xif.off_instr = $urandom; xif.off_id = 4'($urandom);
    xif.off_rs1 = $urandom; xif.off_rs2 = $urandom;
    kill = 1'b0;
    for (int c = 0; c < delay; c++) begin
      xif.off_kill = (c == kill_at);
      kill |= (c == kill_at);
      xif.x_issue_ready = 0;
      xif.x_issue_accept = 1'($urandom);
      xif.x_issue_writeback = 1'($urandom);
      tick();
    end
    xif.off_kill = (kill_at == delay);
    kill |= (kill_at == delay);
    xif.x_issue_ready = 1; xif.x_issue_accept = acc; xif.x_issue_writeback = wb;
    if (res_en) begin
      xif.x_result_valid = 1; xif.x_result_id = res_id; xif.x_result_data = res_data;
      xif.x_result_rd = res_rd; xif.x_result_we = 1; xif.rf_stall = 0;
      res_expect(res_id, res_data, res_rd, 1'b1);
    end
    q_cmt.push_back({id, kill || !acc});
    if (acc && wb && !kill) ids.push_back(id);
    tick();
    xif.x_issue_ready = 0; xif.x_issue_accept = 0; xif.x_issue_writeback = 0;
    xif.off_kill = 0; xif.x_result_valid = 0;
    chk("cnt_after_issue", 64'(xif.outstanding_cnt), 64'(ids.size()));
    chk("err_after_issue", 64'(xif.err_unexp_result), 64'(model_err));
    tick();
  endtask

  task automatic send_result(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd,
                             input bit we, input int stall);
    xif.x_result_valid = 1; xif.x_result_id = id; xif.x_result_data = data;
    xif.x_result_rd = rd; xif.x_result_we = we;
    for (int c = 0; c < stall; c++) begin
      xif.rf_stall = 1;
      tick();
    end
    xif.rf_stall = 0;
    res_expect(id, data, rd, we);
    tick();
    xif.x_result_valid = 0;
    chk("cnt_after_result", 64'(xif.outstanding_cnt), 64'(ids.size()));
    chk("err_after_result", 64'(xif.err_unexp_result), 64'(model_err));
  endtask

  // Monitor: compares DUT outputs against the queued expectations, away from the active edge.
  iss_t m_ie;
  cmt_t m_ce;
  res_t m_re;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_issue  = 1'b0;
      exp_commit = 1'b0;
    end else begin
      chk("commit_valid", 64'(xif.x_commit_valid), 64'(exp_commit));
      chk("off_done", 64'(xif.off_done), 64'(exp_commit));
      if (exp_commit && xif.x_commit_valid) begin
        chk("off_ready_commit", 64'(xif.off_ready), 64'(0));
        if (q_cmt.size() == 0) fail("commit_queue");
        else begin
          m_ce = q_cmt.pop_front();
          chk("commit_id", 64'(xif.x_commit_id), 64'(m_ce.id));
          chk("commit_kill", 64'(xif.x_commit_kill), 64'(m_ce.kill));
          chk("off_accept", 64'(xif.off_accept), 64'(!m_ce.kill));
        end
      end else begin
        chk("off_accept_idle", 64'(xif.off_accept), 64'(0));
      end
      if (exp_issue) chk("issue_latency", 64'(xif.x_issue_valid), 64'(1));
      if (xif.x_issue_valid) begin
        chk("off_ready_issue", 64'(xif.off_ready), 64'(0));
        chk("rs_valid", 64'(xif.x_issue_rs_valid), 64'(3));
        if (q_iss.size() == 0) fail("issue_queue");
        else begin
          m_ie = q_iss[0];
          chk("issue_instr", 64'(xif.x_issue_instr), 64'(m_ie.instr));
          chk("issue_id", 64'(xif.x_issue_id), 64'(m_ie.id));
          chk("issue_rs0", 64'(xif.x_issue_rs0), 64'(m_ie.rs0));
          chk("issue_rs1", 64'(xif.x_issue_rs1), 64'(m_ie.rs1));
          if (xif.x_issue_ready) void'(q_iss.pop_front());
        end
      end
      exp_issue  = xif.off_valid && xif.off_ready;
      exp_commit = xif.x_issue_valid && xif.x_issue_ready;
      chk("result_ready", 64'(xif.x_result_ready), 64'(!xif.rf_stall));
      if (xif.x_result_valid && !xif.rf_stall) begin
        if (q_res.size() == 0) fail("result_queue");
        else begin
          m_re = q_res.pop_front();
          chk("rf_we", 64'(xif.rf_we), 64'(m_re.we));
          if (m_re.we) begin
            chk("rf_waddr", 64'(xif.rf_waddr), 64'(m_re.rd));
            chk("rf_wdata", 64'(xif.rf_wdata), 64'(m_re.data));
          end
        end
      end else begin
        chk("rf_we_idle", 64'(xif.rf_we), 64'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rid;
    int         kill_at;
    bit         res_en;
    drive_idle();
    model_err = 1'b0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_issue_valid", 64'(xif.x_issue_valid), 64'(0));
    chk("rst_commit_valid", 64'(xif.x_commit_valid), 64'(0));
    chk("rst_off_done", 64'(xif.off_done), 64'(0));
    chk("rst_rf_we", 64'(xif.rf_we), 64'(0));
    chk("rst_cnt", 64'(xif.outstanding_cnt), 64'(0));
    chk("rst_err", 64'(xif.err_unexp_result), 64'(0));
    chk("rst_result_ready", 64'(xif.x_result_ready), 64'(1));
    chk("rst_rs_valid", 64'(xif.x_issue_rs_valid), 64'(0));
    chk("rst_issue_instr", 64'(xif.x_issue_instr), 64'(0));
    rst_n = 1;
    tick();

    // single op: add x5,x1,x2
    check_ready(4'd3);
    offload(4'd3, 32'h002082B3, 32'h11, 32'h22, 1, 1, 0, -1, 0, 0, 0, 0);
    send_result(4'd3, 32'hDEADBEEF, 5'd5, 1, 0);
    // issue backpressure
    offload(4'd1, 32'h00A00033, 32'hA5A5_0001, 32'h5A5A_0002, 1, 1, 5, -1, 0, 0, 0, 0);
    send_result(4'd1, 32'h1357_9BDF, 5'd1, 1, 0);
    // kill pulsed during ISSUE; rejection; accepted without writeback
    offload(4'd2, 32'h0000_1033, 32'h3, 32'h4, 1, 1, 3, 1, 0, 0, 0, 0);
    offload(4'd6, 32'h0000_2033, 32'h5, 32'h6, 0, 1, 1, -1, 0, 0, 0, 0);
    offload(4'd6, 32'h0000_3033, 32'h7, 32'h8, 1, 0, 0, -1, 0, 0, 0, 0);
    // fill the table
    for (int k = 4; k < 8; k++) offload(4'(k), 32'h100 + k, 32'(k), 32'(k * 3), 1, 1, k - 4, -1, 0, 0, 0, 0);
    check_ready(4'd8);
    check_ready(4'd5);
    send_result(4'd4, 32'h4444_4444, 5'd9, 1, 0);
    check_ready(4'd8);
    // allocate id 2 while id 5 frees
    offload(4'd2, 32'h0222_0033, 32'h9, 32'hA, 1, 1, 1, -1, 1, 4'd5, 32'hCAFE_F00D, 5'd12);
    // unknown id, stalled write, rd=x0, we=0
    send_result(4'd9, 32'h1234_5678, 5'd7, 1, 0);
    send_result(4'd6, 32'h0BAD_F00D, 5'd3, 1, 3);
    send_result(4'd7, 32'h7777_7777, 5'd0, 1, 0);
    send_result(4'd2, 32'h2222_2222, 5'd8, 0, 0);

    // reset while an instruction sits in ISSUE: no commit may appear
    check_ready(4'hA);
    offload_start: begin
      xif.off_valid = 1; xif.off_instr = 32'hABCD_0033; xif.off_rs1 = 1; xif.off_rs2 = 2;
      q_iss.push_back({32'hABCD_0033, 4'hA, 32'd1, 32'd2});
      tick();
      xif.off_valid = 0;
      tick();
      rst_n = 0;
      q_iss.delete(); q_cmt.delete(); ids.delete(); model_err = 1'b0;
      #1;
      chk("midrst_issue_valid", 64'(xif.x_issue_valid), 64'(0));
      chk("midrst_cnt", 64'(xif.outstanding_cnt), 64'(0));
      chk("midrst_err", 64'(xif.err_unexp_result), 64'(0));
      tick(); tick();
      rst_n = 1;
      tick();
    end

    for (int it = 0; it < 250; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        rid = 4'($urandom);
        check_ready(rid);
        if ((ids.size() < N) && !in_set(rid)) begin
          kill_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
          res_en  = (ids.size() > 0) && ($urandom_range(0, 3) == 0);
          offload(rid, $urandom, $urandom, $urandom, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 5) != 0, int'($urandom_range(0, 3)), kill_at, res_en,
                  res_en ? ids[0] : 4'd0, $urandom, 5'($urandom));
        end
      end else if (ids.size() > 0 && r < 9) begin
        send_result(ids[$urandom_range(0, ids.size() - 1)], $urandom, 5'($urandom),
                    1'($urandom), int'($urandom_range(0, 2)));
      end else begin
        send_result(4'($urandom), $urandom, 5'($urandom), 1'($urandom), 0);
      end
    end
    while (ids.size() > 0) send_result(ids[0], $urandom, 5'($urandom), 1, 0);
    tick();
    chk("end_q_iss", 64'(q_iss.size()), 64'(0));
    chk("end_q_cmt", 64'(q_cmt.size()), 64'(0));
    chk("end_q_res", 64'(q_res.size()), 64'(0));
    chk("end_cnt", 64'(xif.outstanding_cnt), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
